// File: rtl/sq_wave_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sq_wave_pkg                                                             |
// | Shared config-select encodings, period floor and code clamp helpers.   |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
package sq_wave_pkg;

  typedef enum logic [1:0] {
    CFG_PERIOD = 2'd0,
    CFG_HIGH   = 2'd1,
    CFG_AMP    = 2'd2,
    CFG_EN     = 2'd3
  } cfg_sel_e;

  localparam int MIN_PERIOD = 2;

  // Signed sum saturated into the unsigned code range [0, 2^code_w-1].
  function automatic int clamp_code(input int value, input int code_w);
    int max_code;
    max_code = (1 << code_w) - 1;
    if (value < 0) begin
      return 0;
    end else if (value > max_code) begin
      return max_code;
    end else begin
      return value;
    end
  endfunction

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sq_wave_gen_multi_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sq_wave_gen_multi_if                                                    |
// | Strobe/config/code bundle; mix_code exists only with SQ_WAVE_MIX_EN.    |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
interface sq_wave_gen_multi_if #(
  parameter int NUM_CH  = 4,
  parameter int CODE_W  = 10,
  parameter int COUNT_W = 19
) ();
  import sq_wave_pkg::*;

  localparam int c_ch_w = ch_idx_w(NUM_CH);

  logic                       next_sample;
  logic                       cfg_we;
  logic [c_ch_w-1:0]          cfg_ch;
  logic [1:0]                 cfg_sel;
  logic [COUNT_W-1:0]         cfg_data;
  logic [NUM_CH*CODE_W-1:0]   code;
`ifdef SQ_WAVE_MIX_EN
  logic [CODE_W-1:0]          mix_code;

  modport master (
    output next_sample, cfg_we, cfg_ch, cfg_sel, cfg_data,
    input  code, mix_code
  );

  modport slave (
    input  next_sample, cfg_we, cfg_ch, cfg_sel, cfg_data,
    output code, mix_code
  );
`else
  modport master (
    output next_sample, cfg_we, cfg_ch, cfg_sel, cfg_data,
    input  code
  );

  modport slave (
    input  next_sample, cfg_we, cfg_ch, cfg_sel, cfg_data,
    output code
  );
`endif

endinterface
`default_nettype wire

// File: rtl/sq_wave_channel.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sq_wave_channel                                                         |
// | One square-wave lane: free-running counter, config regs, code register.|
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module sq_wave_channel
  import sq_wave_pkg::*;
#(
  parameter int CODE_W         = 10,
  parameter int COUNT_W        = 19,
  parameter int MID            = 512,
  parameter int DEFAULT_PERIOD = 284090,
  parameter int DEFAULT_AMP    = 50
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               i_next_sample,
  input  wire logic               i_wr_period,
  input  wire logic               i_wr_high,
  input  wire logic               i_wr_amp,
  input  wire logic               i_wr_en,
  input  wire logic [COUNT_W-1:0] i_cfg_data,
  output logic      [CODE_W-1:0]  o_code
);

  localparam logic [COUNT_W-1:0] c_min_period = COUNT_W'(MIN_PERIOD);
  localparam logic [COUNT_W-1:0] c_def_period = COUNT_W'(DEFAULT_PERIOD);
  localparam logic [COUNT_W-1:0] c_def_high   = COUNT_W'(DEFAULT_PERIOD / 2);
  localparam logic [CODE_W-1:0]  c_def_amp    = CODE_W'(DEFAULT_AMP);
  localparam logic [CODE_W-1:0]  c_mid        = CODE_W'(MID);

  logic [COUNT_W-1:0] r_count;
  logic [COUNT_W-1:0] r_period;
  logic [COUNT_W-1:0] r_high;
  logic [CODE_W-1:0]  r_amp;
  logic               r_en;
  logic [CODE_W-1:0]  r_code;

  logic               w_high;
  logic               w_wrap;
  logic [CODE_W-1:0]  w_code_hi;
  logic [CODE_W-1:0]  w_code_lo;

  // high_time >= period keeps count < high forever; high_time = 0 never does.
  assign w_high    = (r_count < r_high);
  assign w_wrap    = (r_count >= (r_period - COUNT_W'(1)));
  assign w_code_hi = CODE_W'(clamp_code(MID + int'(r_amp), CODE_W));
  assign w_code_lo = CODE_W'(clamp_code(MID - int'(r_amp), CODE_W));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count  <= '0;
      r_period <= c_def_period;
      r_high   <= c_def_high;
      r_amp    <= c_def_amp;
      r_en     <= 1'b1;
      r_code   <= c_mid;
    end else begin
      if (i_wr_period) begin
        r_period <= (i_cfg_data < c_min_period) ? c_min_period : i_cfg_data;
      end
      if (i_wr_high) begin
        r_high <= i_cfg_data;
      end
      if (i_wr_amp) begin
        r_amp <= i_cfg_data[CODE_W-1:0];
      end
      if (i_wr_en) begin
        r_en <= i_cfg_data[0];
      end

      // Period writes restart the phase; a disabled lane parks its counter at 0.
      if (i_wr_period || !r_en || w_wrap) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + COUNT_W'(1);
      end

      // Sampling reads the registered state, so a same-edge config write is not seen yet.
      if (i_next_sample) begin
        if (!r_en) begin
          r_code <= c_mid;
        end else if (w_high) begin
          r_code <= w_code_hi;
        end else begin
          r_code <= w_code_lo;
        end
      end
    end
  end

  assign o_code = r_code;

endmodule
`default_nettype wire

// File: rtl/sq_wave_gen_multi.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | sq_wave_gen_multi                                                       |
// | N-channel square-wave code generator; optional saturating mixer built  |
// | when SQ_WAVE_MIX_EN is defined.                                         |
// | Revision: 1.0                                                           |
// +-------------------------------------------------------------------------+
module sq_wave_gen_multi
  import sq_wave_pkg::*;
#(
  parameter int NUM_CH         = 4,
  parameter int CODE_W         = 10,
  parameter int COUNT_W        = 19,
  parameter int MID            = 512,
  parameter int DEFAULT_PERIOD = 284090,
  parameter int DEFAULT_AMP    = 50
) (
  input  wire logic          clk,
  input  wire logic          rst,
  sq_wave_gen_multi_if.slave bus
);

  logic [CODE_W-1:0] w_lane [NUM_CH];
  logic [NUM_CH-1:0] w_wr_period;
  logic [NUM_CH-1:0] w_wr_high;
  logic [NUM_CH-1:0] w_wr_amp;
  logic [NUM_CH-1:0] w_wr_en;

  // Channel indices beyond NUM_CH match no lane, so those writes are dropped.
  always_comb begin
    w_wr_period = '0;
    w_wr_high   = '0;
    w_wr_amp    = '0;
    w_wr_en     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (bus.cfg_we && (int'(bus.cfg_ch) == k)) begin
        w_wr_period[k] = (bus.cfg_sel == CFG_PERIOD);
        w_wr_high[k]   = (bus.cfg_sel == CFG_HIGH);
        w_wr_amp[k]    = (bus.cfg_sel == CFG_AMP);
        w_wr_en[k]     = (bus.cfg_sel == CFG_EN);
      end
    end
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      sq_wave_channel #(
        .CODE_W         (CODE_W),
        .COUNT_W        (COUNT_W),
        .MID            (MID),
        .DEFAULT_PERIOD (DEFAULT_PERIOD),
        .DEFAULT_AMP    (DEFAULT_AMP)
      ) u_ch (
        .clk           (clk),
        .rst           (rst),
        .i_next_sample (bus.next_sample),
        .i_wr_period   (w_wr_period[k]),
        .i_wr_high     (w_wr_high[k]),
        .i_wr_amp      (w_wr_amp[k]),
        .i_wr_en       (w_wr_en[k]),
        .i_cfg_data    (bus.cfg_data),
        .o_code        (w_lane[k])
      );
    end
  endgenerate

  always_comb begin
    bus.code = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      bus.code[k*CODE_W +: CODE_W] = w_lane[k];
    end
  end

`ifdef SQ_WAVE_MIX_EN
  localparam logic [CODE_W-1:0] c_mid = CODE_W'(MID);

  logic              r_upd;
  logic [CODE_W-1:0] r_mix;
  int                w_mix_sum;

  always_comb begin
    w_mix_sum = MID;
    for (int k = 0; k < NUM_CH; k++) begin
      w_mix_sum = w_mix_sum + (int'(w_lane[k]) - MID);
    end
  end

  // Mix one edge after the lanes refresh, so it always sees a coherent set of codes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_upd <= 1'b0;
      r_mix <= c_mid;
    end else begin
      r_upd <= bus.next_sample;
      if (r_upd) begin
        r_mix <= CODE_W'(clamp_code(w_mix_sum, CODE_W));
      end
    end
  end

  assign bus.mix_code = r_mix;
`else
`endif

endmodule
`default_nettype wire
